// File: rtl/mem_access_stage.sv
// mem_access_stage: RV32I load/store stage over a req/ack data bus; define MISALIGN_TRAP_EN to trap misaligned halfword/word accesses.
`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 11
`endif
`ifndef OPCODE_LOAD
`define OPCODE_LOAD 5
`endif
`ifndef OPCODE_STORE
`define OPCODE_STORE 6
`endif
`ifndef EXCEPTION_WIDTH
`define EXCEPTION_WIDTH 8
`endif
`ifndef LOAD_MISALIGNED
`define LOAD_MISALIGNED 4
`endif
`ifndef LOAD_ACCESS_FAULT
`define LOAD_ACCESS_FAULT 5
`endif
`ifndef STORE_MISALIGNED
`define STORE_MISALIGNED 6
`endif
`ifndef STORE_ACCESS_FAULT
`define STORE_ACCESS_FAULT 7
`endif

module mem_access_stage #(
    parameter logic [7:0] DMEM_TIMEOUT = 8'd255
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic [`OPCODE_WIDTH-1:0]    prev_opcode_type,
    input  logic [2:0]                  prev_funct3,
    input  logic [31:0]                 prev_alu_result,
    input  logic [31:0]                 prev_rs2_data,
    input  logic [4:0]                  prev_rd,
    input  logic [31:0]                 prev_rd_wdata,
    input  logic                        prev_rd_w_en,
    input  logic                        prev_rd_valid,
    input  logic [31:0]                 prev_pc,
    input  logic [`EXCEPTION_WIDTH-1:0] prev_exception,
    output logic                        dmem_req,
    output logic                        dmem_we,
    output logic [31:0]                 dmem_addr,
    output logic [31:0]                 dmem_wdata,
    output logic [3:0]                  dmem_sel,
    input  logic                        dmem_ack,
    input  logic [31:0]                 dmem_rdata,
    output logic [4:0]                  rd,
    output logic [31:0]                 rd_wdata,
    output logic                        rd_w_en,
    output logic                        rd_valid,
    output logic [31:0]                 pc,
    output logic [`EXCEPTION_WIDTH-1:0] exception,
    input  logic                        prev_clk_en,
    output logic                        clk_en,
    input  logic                        prev_stall,
    output logic                        stall,
    input  logic                        prev_flush,
    output logic                        flush
);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t state;
    logic [7:0] cnt;
    logic ld_q, wen_q, drop_q;
    logic [2:0] f3_q;
    logic [1:0] a_q;
    logic is_load, is_store, mem_op, f3_ok, mis, fault, bus_op, accept, tmo;
    logic [3:0] st_sel;
    logic [31:0] st_wdata, sh_data, ld_val;
    logic [7:0] ld_b;
    logic [15:0] ld_h;
    logic [`EXCEPTION_WIDTH-1:0] exc_l;
    logic unused_ok;

    assign unused_ok = &{1'b0, prev_opcode_type};
    assign is_load   = prev_opcode_type[`OPCODE_LOAD];
    assign is_store  = prev_opcode_type[`OPCODE_STORE];
    assign mem_op    = is_load || is_store;
    assign f3_ok     = is_load ? (prev_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})
                               : (!prev_funct3[2] && prev_funct3[1:0] != 2'b11);
`ifdef MISALIGN_TRAP_EN
    assign mis = (prev_funct3[1:0] == 2'b01 && prev_alu_result[0]) ||
                 (prev_funct3[1:0] == 2'b10 && prev_alu_result[1:0] != 2'b00);
`else
    assign mis = 1'b0;
`endif
    assign fault  = mem_op && !f3_ok;
    assign bus_op = mem_op && f3_ok && !mis;
    assign accept = prev_clk_en && !prev_stall && !prev_flush && state == IDLE;
    assign tmo    = DMEM_TIMEOUT != 8'd0 && cnt == DMEM_TIMEOUT - 8'd1;
    // Stall releases in the completing cycle so execute advances exactly once per access.
    assign stall  = prev_stall || (state == BUSY && !dmem_ack && !tmo) || (accept && bus_op);
    assign flush  = prev_flush;

    always_comb begin
        exc_l = '0;
        exc_l[`LOAD_ACCESS_FAULT]  = fault && is_load;
        exc_l[`STORE_ACCESS_FAULT] = fault && is_store;
        exc_l[`LOAD_MISALIGNED]    = mem_op && f3_ok && mis && is_load;
        exc_l[`STORE_MISALIGNED]   = mem_op && f3_ok && mis && is_store;
    end

    assign st_sel   = prev_funct3[1:0] == 2'b00 ? 4'b0001 << prev_alu_result[1:0] :
                      prev_funct3[1:0] == 2'b01 ? (prev_alu_result[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign st_wdata = prev_funct3[1:0] == 2'b00 ? {4{prev_rs2_data[7:0]}} :
                      prev_funct3[1:0] == 2'b01 ? {2{prev_rs2_data[15:0]}} : prev_rs2_data;

    assign sh_data = dmem_rdata >> {a_q, 3'b000};
    assign ld_b    = sh_data[7:0];
    assign ld_h    = a_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    assign ld_val  = f3_q == 3'b000 ? {{24{ld_b[7]}}, ld_b} :
                     f3_q == 3'b001 ? {{16{ld_h[15]}}, ld_h} :
                     f3_q == 3'b100 ? {24'd0, ld_b} :
                     f3_q == 3'b101 ? {16'd0, ld_h} : dmem_rdata;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= IDLE;
            cnt        <= '0;
            ld_q       <= 1'b0;
            wen_q      <= 1'b0;
            drop_q     <= 1'b0;
            f3_q       <= '0;
            a_q        <= '0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            dmem_sel   <= '0;
            rd         <= '0;
            rd_wdata   <= '0;
            rd_w_en    <= 1'b0;
            rd_valid   <= 1'b0;
            pc         <= '0;
            exception  <= '0;
            clk_en     <= 1'b0;
        end else if (state == IDLE) begin
            if (accept) begin
                rd        <= prev_rd;
                pc        <= prev_pc;
                exception <= prev_exception | exc_l;
                rd_wdata  <= prev_rd_wdata;
                rd_valid  <= prev_rd_valid;
                rd_w_en   <= prev_rd_w_en && !mem_op;
                ld_q      <= is_load;
                wen_q     <= prev_rd_w_en;
                f3_q      <= prev_funct3;
                a_q       <= prev_alu_result[1:0];
                drop_q    <= 1'b0;
                cnt       <= '0;
                dmem_req  <= bus_op;
                clk_en    <= !bus_op;
                state     <= bus_op ? BUSY : IDLE;
                if (bus_op) begin
                    dmem_we    <= is_store;
                    dmem_addr  <= {prev_alu_result[31:2], 2'b00};
                    dmem_sel   <= st_sel;
                    dmem_wdata <= st_wdata;
                end
            end else begin
                clk_en <= prev_stall && !prev_flush && clk_en;
            end
        end else if (dmem_ack || tmo) begin
            state    <= IDLE;
            dmem_req <= 1'b0;
            clk_en   <= !(drop_q || prev_flush);
            if (dmem_ack && ld_q) begin
                rd_wdata <= ld_val;
                rd_valid <= 1'b1;
                rd_w_en  <= wen_q;
            end else if (!dmem_ack) begin
                rd_w_en <= 1'b0;
                if (ld_q)
                    exception[`LOAD_ACCESS_FAULT] <= 1'b1;
                else
                    exception[`STORE_ACCESS_FAULT] <= 1'b1;
            end
        end else begin
            cnt    <= cnt + 8'd1;
            drop_q <= drop_q || prev_flush;
        end
    end
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed vectors and multi-cycle sequences for mem_access_stage (DMEM_TIMEOUT=4).
`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 11
`endif
`ifndef OPCODE_LOAD
`define OPCODE_LOAD 5
`endif
`ifndef OPCODE_STORE
`define OPCODE_STORE 6
`endif
`ifndef EXCEPTION_WIDTH
`define EXCEPTION_WIDTH 8
`endif
`ifndef LOAD_MISALIGNED
`define LOAD_MISALIGNED 4
`endif
`ifndef LOAD_ACCESS_FAULT
`define LOAD_ACCESS_FAULT 5
`endif
`ifndef STORE_MISALIGNED
`define STORE_MISALIGNED 6
`endif
`ifndef STORE_ACCESS_FAULT
`define STORE_ACCESS_FAULT 7
`endif

module tb_mem_access_stage;
    localparam logic [10:0] LD  = 11'b000_0010_0000;
    localparam logic [10:0] ST  = 11'b000_0100_0000;
    localparam logic [10:0] ALU = 11'b001_0000_0000;

    logic clk = 1'b0, rstn = 1'b0;
    logic [`OPCODE_WIDTH-1:0] prev_opcode_type = '0;
    logic [2:0] prev_funct3 = '0;
    logic [31:0] prev_alu_result = '0, prev_rs2_data = '0, prev_rd_wdata = '0, prev_pc = '0;
    logic [4:0] prev_rd = '0;
    logic prev_rd_w_en = 1'b0, prev_rd_valid = 1'b0;
    logic [`EXCEPTION_WIDTH-1:0] prev_exception = '0;
    logic dmem_req, dmem_we, dmem_ack = 1'b0;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata = '0;
    logic [3:0] dmem_sel;
    logic [4:0] rd;
    logic [31:0] rd_wdata, pc;
    logic rd_w_en, rd_valid, clk_en, stall, flush;
    logic [`EXCEPTION_WIDTH-1:0] exception;
    logic prev_clk_en = 1'b0, prev_stall = 1'b0, prev_flush = 1'b0;
    int total = 0, bad = 0;

    mem_access_stage #(.DMEM_TIMEOUT(8'd4)) dut (
        .clk(clk), .rstn(rstn),
        .prev_opcode_type(prev_opcode_type), .prev_funct3(prev_funct3),
        .prev_alu_result(prev_alu_result), .prev_rs2_data(prev_rs2_data),
        .prev_rd(prev_rd), .prev_rd_wdata(prev_rd_wdata), .prev_rd_w_en(prev_rd_w_en),
        .prev_rd_valid(prev_rd_valid), .prev_pc(prev_pc), .prev_exception(prev_exception),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_sel(dmem_sel), .dmem_ack(dmem_ack),
        .dmem_rdata(dmem_rdata), .rd(rd), .rd_wdata(rd_wdata), .rd_w_en(rd_w_en),
        .rd_valid(rd_valid), .pc(pc), .exception(exception),
        .prev_clk_en(prev_clk_en), .clk_en(clk_en), .prev_stall(prev_stall),
        .stall(stall), .prev_flush(prev_flush), .flush(flush)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [10:0] op;
        logic [2:0]  f3;
        logic [31:0] addr, rs2, rwd, rdata;
        logic [7:0]  exc_in;
        logic        bus;
        logic [3:0]  sel;
        logic [31:0] wdata, exp_rd;
        logic        exp_wen;
        logic [7:0]  exp_exc;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [10:0] op, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] rs2, input logic [31:0] rwd, input logic [7:0] exc, input int tag);
        prev_opcode_type = op;
        prev_funct3 = f3;
        prev_alu_result = addr;
        prev_rs2_data = rs2;
        prev_rd_wdata = rwd;
        prev_rd = 5'(tag + 1);
        prev_pc = 32'h1000 + 32'(tag * 4);
        prev_rd_w_en = 1'b1;
        prev_rd_valid = 1'b1;
        prev_exception = exc;
        prev_clk_en = 1'b1;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        drive(v.op, v.f3, v.addr, v.rs2, v.rwd, v.exc_in, idx);
        #1 chk($sformatf("v%0d_stall_accept", idx), stall, v.bus);
        tick();
        prev_clk_en = 1'b0;
        if (v.bus) begin
            chk($sformatf("v%0d_req", idx), dmem_req, 1);
            chk($sformatf("v%0d_we", idx), dmem_we, v.op == ST);
            chk($sformatf("v%0d_addr", idx), dmem_addr, {v.addr[31:2], 2'b00});
            if (v.op == ST) begin
                chk($sformatf("v%0d_sel", idx), dmem_sel, v.sel);
                chk($sformatf("v%0d_wdata", idx), dmem_wdata, v.wdata);
            end
            dmem_ack = 1'b1;
            dmem_rdata = v.rdata;
            #1 chk($sformatf("v%0d_stall_ack", idx), stall, 0);
            tick();
            dmem_ack = 1'b0;
        end
        chk($sformatf("v%0d_clk_en", idx), clk_en, 1);
        chk($sformatf("v%0d_req_low", idx), dmem_req, 0);
        chk($sformatf("v%0d_rd_wdata", idx), rd_wdata, v.exp_rd);
        chk($sformatf("v%0d_rd_w_en", idx), rd_w_en, v.exp_wen);
        chk($sformatf("v%0d_rd_valid", idx), rd_valid, 1);
        chk($sformatf("v%0d_exc", idx), exception, v.exp_exc);
        chk($sformatf("v%0d_rd", idx), rd, idx + 1);
        chk($sformatf("v%0d_pc", idx), pc, 32'h1000 + 32'(idx * 4));
        tick();
        chk($sformatf("v%0d_clk_en_drop", idx), clk_en, 0);
    endtask

    vec_t vecs[12];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, ce, st;
        logic seen;
        vecs[0]  = '{LD,  3'b000, 32'h103, 32'h0,        32'h0,  32'h80123456, 8'h00, 1'b1, 4'h0, 32'h0,        32'hFFFFFF80, 1'b1, 8'h00};
        vecs[1]  = '{LD,  3'b100, 32'h103, 32'h0,        32'h0,  32'h80123456, 8'h00, 1'b1, 4'h0, 32'h0,        32'h00000080, 1'b1, 8'h00};
        vecs[2]  = '{LD,  3'b101, 32'h102, 32'h0,        32'h0,  32'hBEEF1234, 8'h00, 1'b1, 4'h0, 32'h0,        32'h0000BEEF, 1'b1, 8'h00};
        vecs[3]  = '{LD,  3'b001, 32'h100, 32'h0,        32'h0,  32'h12348001, 8'h00, 1'b1, 4'h0, 32'h0,        32'hFFFF8001, 1'b1, 8'h00};
        vecs[4]  = '{LD,  3'b010, 32'h200, 32'h0,        32'h0,  32'hCAFEF00D, 8'h00, 1'b1, 4'h0, 32'h0,        32'hCAFEF00D, 1'b1, 8'h00};
        vecs[5]  = '{ST,  3'b001, 32'h102, 32'h0000ABCD, 32'h11, 32'h0,        8'h00, 1'b1, 4'hC, 32'hABCDABCD, 32'h00000011, 1'b0, 8'h00};
        vecs[6]  = '{ST,  3'b000, 32'h101, 32'h12345677, 32'h22, 32'h0,        8'h00, 1'b1, 4'h2, 32'h77777777, 32'h00000022, 1'b0, 8'h00};
        vecs[7]  = '{ST,  3'b010, 32'h104, 32'h01020304, 32'h0,  32'h0,        8'h00, 1'b1, 4'hF, 32'h01020304, 32'h00000000, 1'b0, 8'h00};
        vecs[8]  = '{ALU, 3'b000, 32'h5,   32'h0,        32'h5,  32'h0,        8'h00, 1'b0, 4'h0, 32'h0,        32'h00000005, 1'b1, 8'h00};
        vecs[9]  = '{ST,  3'b011, 32'h108, 32'h0,        32'h33, 32'h0,        8'h00, 1'b0, 4'h0, 32'h0,        32'h00000033, 1'b0, 8'h80};
        vecs[10] = '{LD,  3'b110, 32'h10C, 32'h0,        32'h44, 32'h0,        8'h00, 1'b0, 4'h0, 32'h0,        32'h00000044, 1'b0, 8'h20};
        vecs[11] = '{ALU, 3'b000, 32'h9,   32'h0,        32'h9,  32'h0,        8'h01, 1'b0, 4'h0, 32'h0,        32'h00000009, 1'b1, 8'h01};

        tick();
        tick();
        chk("rst_req", dmem_req, 0);
        chk("rst_clk_en", clk_en, 0);
        chk("rst_exc", exception, 0);
        chk("rst_rd_w_en", rd_w_en, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_stall", stall, 0);
        rstn = 1'b1;
        tick();

        dmem_ack = 1'b1;
        tick();
        dmem_ack = 1'b0;
        chk("idle_ack_req", dmem_req, 0);
        chk("idle_ack_clk_en", clk_en, 0);

        for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

        // SW with ack three cycles after req; execute holds while stalled
        drive(ST, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 8'h00, 20);
        n = 0; ce = 0; st = 0;
        for (int c = 0; c < 9; c++) begin
            prev_clk_en = c <= 4;
            dmem_ack = c == 4;
            #1;
            if (stall) st++;
            if (clk_en) ce++;
            if (dmem_req) n++;
            if (c == 1) begin
                chk("sw_we", dmem_we, 1);
                chk("sw_sel", dmem_sel, 4'hF);
                chk("sw_wdata", dmem_wdata, 32'hDEADBEEF);
            end
            if (c == 5) chk("sw_rd_w_en", rd_w_en, 0);
            tick();
        end
        dmem_ack = 1'b0;
        chk("sw_stall_cycles", st, 4);
        chk("sw_clk_en_pulses", ce, 1);
        chk("sw_req_cycles", n, 4);

        // back-to-back ALU ops
        drive(ALU, 3'b000, 32'h0, 32'h0, 32'h5, 8'h00, 21);
        #1 chk("b2b_stall0", stall, 0);
        tick();
        chk("b2b_first", rd_wdata, 5);
        chk("b2b_first_en", clk_en, 1);
        drive(ALU, 3'b000, 32'h0, 32'h0, 32'h7, 8'h00, 22);
        #1 chk("b2b_stall1", stall, 0);
        tick();
        prev_clk_en = 1'b0;
        chk("b2b_second", rd_wdata, 7);
        chk("b2b_second_en", clk_en, 1);
        tick();
        chk("b2b_bubble", clk_en, 0);

        // flush while BUSY: bus completes, result dropped
        drive(LD, 3'b010, 32'h40, 32'h0, 32'h0, 8'h00, 23);
        tick();
        prev_clk_en = 1'b0;
        prev_flush = 1'b1;
        #1 chk("flush_out", flush, 1);
        chk("flush_req", dmem_req, 1);
        tick();
        prev_flush = 1'b0;
        dmem_ack = 1'b1;
        dmem_rdata = 32'h12345678;
        tick();
        dmem_ack = 1'b0;
        chk("flush_req_low", dmem_req, 0);
        chk("flush_clk_en", clk_en, 0);

        // timeout with no ack
        drive(LD, 3'b010, 32'h300, 32'h0, 32'h0, 8'h00, 24);
        tick();
        prev_clk_en = 1'b0;
        n = 0;
        seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            if (dmem_req) begin
                n++;
                tick();
            end else begin
                seen = 1'b1;
                chk("to_clk_en", clk_en, 1);
                chk("to_fault", exception[`LOAD_ACCESS_FAULT], 1);
                chk("to_rd_w_en", rd_w_en, 0);
            end
        end
        chk("to_ended", seen, 1);
        chk("to_req_cycles", n, 4);
        tick();

        // reset in the middle of a BUSY store
        drive(ST, 3'b010, 32'h400, 32'h55, 32'h0, 8'h00, 25);
        tick();
        prev_clk_en = 1'b0;
        chk("rst2_req_busy", dmem_req, 1);
        rstn = 1'b0;
        tick();
        chk("rst2_req", dmem_req, 0);
        chk("rst2_clk_en", clk_en, 0);
        chk("rst2_stall", stall, 0);
        rstn = 1'b1;
        tick();

        // misaligned word load
        drive(LD, 3'b010, 32'h101, 32'h0, 32'h0, 8'h00, 26);
        tick();
        prev_clk_en = 1'b0;
`ifdef MISALIGN_TRAP_EN
        chk("mis_req", dmem_req, 0);
        chk("mis_clk_en", clk_en, 1);
        chk("mis_exc", exception[`LOAD_MISALIGNED], 1);
        chk("mis_rd_w_en", rd_w_en, 0);
`else
        chk("mis_req", dmem_req, 1);
        chk("mis_addr", dmem_addr, 32'h100);
        chk("mis_sel", dmem_sel, 4'hF);
        dmem_ack = 1'b1;
        dmem_rdata = 32'hA5A5A5A5;
        tick();
        dmem_ack = 1'b0;
        chk("mis_rd_wdata", rd_wdata, 32'hA5A5A5A5);
        chk("mis_exc", exception, 0);
`endif
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
